tff_counter: RTL

TFF_COUNTER -- requirements
Module: tff_counter

---
 rtl/tff_counter.sv | 64 ++++++
 1 files changed

// File: rtl/tff_counter.sv
// rtl/tff_counter.sv - up/down counter built from toggle stages, with terminal count and sticky boundary flag
module tff_counter #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] count_q, count_d, toggle;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   ones_c, zeros_c;

  // ones_c[i] / zeros_c[i]: all bits below i are 1 / 0; the top entry spans the whole count.
  assign ones_c[0]  = 1'b1;
  assign zeros_c[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    assign ones_c[i+1]  = ones_c[i] & count_q[i];
    assign zeros_c[i+1] = zeros_c[i] & ~count_q[i];
  end

  assign tc = en & (up ? ones_c[WIDTH] : zeros_c[WIDTH]);

  always_comb begin
    toggle = {WIDTH{en}} & (up ? ones_c[WIDTH-1:0] : zeros_c[WIDTH-1:0]);
    if ((SATURATE != 0) && tc) toggle = '0;
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_val;
    end else begin
      count_d = count_q ^ toggle;
      if (tc) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q   = count_q;
  assign ovf = ovf_q;

endmodule
